// File: rtl/rs232_pkg.sv
// Shared definitions for the configurable RS232 transmitter and the future receiver:
// parity modes, FSM state encodings and a constant clog2 helper.
package rs232_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  function automatic int unsigned clog2(input longint unsigned value);
    longint unsigned rem;
    int unsigned     res;
    res = 0;
    rem = (value > 1) ? value - 1 : 0;
    while (rem > 0) begin
      rem = rem >> 1;
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rs232_baud_gen.sv
// Fractional bit-rate generator: a phase accumulator advanced by BAUD_RATE each
// running cycle, producing one tick per bit period with no long-term drift.
module rs232_baud_gen
  import rs232_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 133000000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned ACC_W = clog2(CLOCK_FREQ + BAUD_RATE);
  localparam logic [ACC_W-1:0] INC = ACC_W'(BAUD_RATE);
  localparam logic [ACC_W-1:0] LIM = ACC_W'(CLOCK_FREQ);

  if (2 * BAUD_RATE > CLOCK_FREQ) begin : g_bad_rate
    $error("rs232_baud_gen: 2*BAUD_RATE must not exceed CLOCK_FREQ");
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  // acc < CLOCK_FREQ always, so acc + BAUD_RATE fits in ACC_W bits
  always_comb begin
    acc_sum = acc + INC;
    tick    = run && (acc_sum >= LIM);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (!run) begin
      acc <= '0;
    end else if (tick) begin
      acc <= acc_sum - LIM;
    end else begin
      acc <= acc_sum;
    end
  end

endmodule

// File: rtl/rs232_send_cfg.sv
// Configurable RS232 transmitter: DATA_BITS data, optional odd/even parity,
// 1 or 2 stop bits, valid/ready input with RTS-gated acceptance.
module rs232_send_cfg
  import rs232_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 133000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic                 rs232_rxd,
  input  logic                 rs232_rts_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("rs232_send_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("rs232_send_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("rs232_send_cfg: STOP_BITS must be 1 or 2");
  end

  localparam bit         HAS_PAR   = (PARITY != PARITY_NONE);
  localparam logic       PAR_INV   = (PARITY == PARITY_ODD);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 tick;

  rs232_baud_gen #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud (
    .clock  (clock),
    .reset_n(reset_n),
    .run    (state != ST_IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      par_bit   <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      rs232_rxd <= 1'b1;
      ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready <= !rs232_rts_n;
          if (valid && ready) begin
            shreg     <= data;
            par_bit   <= (^data) ^ PAR_INV;
            rs232_rxd <= 1'b0;
            busy      <= 1'b1;
            ready     <= 1'b0;
            state     <= ST_START;
          end
        end
        ST_START: if (tick) begin
          rs232_rxd <= shreg[0];
          shreg     <= shreg >> 1;
          bit_cnt   <= 4'd1;
          state     <= ST_DATA;
        end
        // bit_cnt counts data bits already on the line
        ST_DATA: if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            stop_cnt <= 1'b0;
            if (HAS_PAR) begin
              rs232_rxd <= par_bit;
              state     <= ST_PAR;
            end else begin
              rs232_rxd <= 1'b1;
              state     <= ST_STOP;
            end
          end else begin
            rs232_rxd <= shreg[0];
            shreg     <= shreg >> 1;
            bit_cnt   <= bit_cnt + 4'd1;
          end
        end
        ST_PAR: if (tick) begin
          rs232_rxd <= 1'b1;
          stop_cnt  <= 1'b0;
          state     <= ST_STOP;
        end
        ST_STOP: if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            busy  <= 1'b0;
            ready <= !rs232_rts_n;
            state <= ST_IDLE;
          end else begin
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          rs232_rxd <= 1'b1;
          busy      <= 1'b0;
          ready     <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
